// File: rtl/gpi_debounce_sync.sv
// Input conditioner for board-level GPI sources such as push-buttons and DIP switches.
// Each bit passes through a synchroniser, an optional inversion and a counter-based debounce.
// The block produces one-cycle edge pulses, sticky event flags and a masked, registered interrupt.

// Per-bit conditioner: sync chain, inversion, debounce counter, edge pulses, sticky flag.
module gpi_debounce_bit #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   CNT_W           = 16,
    parameter logic INVERT          = 1'b0,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic warm,
    input  logic evt_clear,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic evt_flag
);

    typedef enum logic {ST_STABLE, ST_PENDING} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   stable_d;
    logic                   rise_d;
    logic                   fall_d;
    logic                   flag_d;

    // Synchroniser chain. It is preloaded with the reset level and shifts towards the MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    assign s = sync_q[SYNC_STAGES-1] ^ INVERT;

    // The state is implied by comparing s with stable.
    // While the chain still holds its reset preload (warm low), the bit is forced to STABLE.
    // This keeps an inverted bit from counting a phantom level straight after reset.
    always_comb begin
        state = ST_STABLE;
        if (warm && (s != stable)) state = ST_PENDING;
    end

    // Next-state logic. Any agreement between s and stable zeroes the count (glitch reject).
    // The final count commits the new level and emits the edge pulse.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        case (state)
            ST_STABLE: cnt_d = '0;
            ST_PENDING: begin
                if (cnt_q == CNT_LAST) begin
                    stable_d = s;
                    rise_d   = s;
                    fall_d   = ~s;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Sticky flag. A pulse arriving in the same cycle as a clear takes priority over the clear.
    always_comb begin
        flag_d = (evt_flag & ~evt_clear) | rise | fall;
    end

    // State registers for the counter, the debounced level, the pulses and the flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            stable   <= RESET_LEVEL;
            rise     <= 1'b0;
            fall     <= 1'b0;
            evt_flag <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable   <= stable_d;
            rise     <= rise_d;
            fall     <= fall_d;
            evt_flag <= flag_d;
        end
    end

endmodule

// Top level: an array of per-bit conditioners, a shared chain-flush tracker and the irq register.
// SYNC_STAGES is legal from 2 to 4. DEBOUNCE_CYCLES must be at least 2.
module gpi_debounce_sync #(
    parameter int               WIDTH           = 1,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] INVERT_MASK     = '0,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] evt_flags,
    input  logic [WIDTH-1:0] evt_clear,
    input  logic [WIDTH-1:0] irq_mask,
    output logic             irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] warm_q;

    // Flush tracker. Its MSB rises on the same edge the last sync stage first holds a real pad sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) warm_q <= '0;
        else       warm_q <= {warm_q[SYNC_STAGES-2:0], 1'b1};
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        gpi_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .INVERT          (INVERT_MASK[gi]),
            .RESET_LEVEL     (RESET_VALUE[gi])
        ) u_bit (
            .clk       (clk),
            .reset     (reset),
            .raw       (raw_in[gi]),
            .warm      (warm_q[SYNC_STAGES-1]),
            .evt_clear (evt_clear[gi]),
            .stable    (stable_out[gi]),
            .rise      (rise_pulse[gi]),
            .fall      (fall_pulse[gi]),
            .evt_flag  (evt_flags[gi])
        );
    end

    // Registered interrupt, one cycle behind the flags and the mask.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq <= 1'b0;
        else       irq <= |(evt_flags & irq_mask);
    end

endmodule
